// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver that turns frames into make/break events with E0 handling
//   Ports: clk_proc, rst (sync, active-high), ps2_clk/ps2_data (raw async bus),
//   key_pressed (last make code), key_flag/key_release/frame_err (1-cycle pulses),
//   key_ext (E0 prefix qualifier for the current key_flag/key_release pulse).
//   Optional macro PS2_PARITY_CHECK_EN: reject frames with bad odd parity.
module ps2_key_rx #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk_proc,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_pressed,
  output logic       key_flag,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;
  state_t                state_q;
  logic [1:0]            clk_s_q, dat_s_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  flt_q, ext_q, brk_q;
  logic [8:0]            sh_q;
  logic [3:0]            bit_q;
  logic [TW-1:0]         to_q;
  logic [7:0]            key_pressed_q;
  logic                  key_flag_q, key_ext_q, key_release_q, frame_err_q;
  logic                  fall, dat, par_ok, timeout;
  assign fall    = flt_q & ~|hist_q;
  assign dat     = dat_s_q[1];
  assign timeout = to_q == TW'(TIMEOUT_CYC - 1);
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok  = ^sh_q;
`else
  assign par_ok  = 1'b1;
`endif
  assign key_pressed = key_pressed_q;
  assign key_flag    = key_flag_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign frame_err   = frame_err_q;
  always_ff @(posedge clk_proc) begin
    if (rst) begin
      clk_s_q <= '1;
      dat_s_q <= '1;
      hist_q  <= '1;
      flt_q   <= 1'b1;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk};
      dat_s_q <= {dat_s_q[0], ps2_data};
      hist_q  <= {hist_q[FILTER_LEN-2:0], clk_s_q[1]};
      flt_q   <= ~|hist_q ? 1'b0 : &hist_q ? 1'b1 : flt_q;
    end
  end
  always_ff @(posedge clk_proc) begin
    if (rst) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      bit_q         <= '0;
      to_q          <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_pressed_q <= '0;
      key_flag_q    <= 1'b0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      key_flag_q    <= 1'b0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (state_q != IDLE && !fall && timeout) begin
        state_q     <= IDLE;
        to_q        <= '0;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else if (state_q != IDLE && !fall) begin
        to_q <= to_q + 1'b1;
      end else begin
        case (state_q)
          IDLE: if (fall && !dat) begin
            state_q <= SHIFT;
            bit_q   <= '0;
            to_q    <= '0;
          end
          SHIFT: begin
            sh_q    <= {dat, sh_q[8:1]};
            bit_q   <= bit_q + 1'b1;
            to_q    <= '0;
            state_q <= bit_q == 4'd8 ? STOP : SHIFT;
          end
          STOP: begin
            state_q <= IDLE;
            to_q    <= '0;
            if (!(dat && par_ok)) begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end else if (sh_q[7:0] == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (sh_q[7:0] == 8'hF0) begin
              brk_q <= 1'b1;
            end else if (!brk_q) begin
              key_pressed_q <= sh_q[7:0];
              key_flag_q    <= 1'b1;
              key_ext_q     <= ext_q;
              ext_q         <= 1'b0;
            end else begin
              key_release_q <= 1'b1;
              key_ext_q     <= ext_q;
              ext_q         <= 1'b0;
              brk_q         <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: table-driven frame vectors plus timeout, glitch and mid-frame reset sequences
module tb_ps2_key_rx;
  localparam int TO = 200;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key_pressed;
  logic key_flag, key_ext, key_release, frame_err;
  int checks = 0, errors = 0;
  int nflag = 0, nrel = 0, nerr = 0, nmulti = 0;
  logic last_ext = 1'b0;
  int bf, br, be;
  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stp;
    int         ef, er, ee;
    logic [7:0] kp;
    logic       ext;
  } vec_t;
  vec_t v[14];
  ps2_key_rx #(.TIMEOUT_CYC(TO), .FILTER_LEN(4)) dut (
    .clk_proc(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_pressed(key_pressed), .key_flag(key_flag), .key_ext(key_ext),
    .key_release(key_release), .frame_err(frame_err));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_flag) nflag++;
    if (key_release) nrel++;
    if (frame_err) nerr++;
    if (int'(key_flag) + int'(key_release) + int'(frame_err) > 1) nmulti++;
    if (key_flag || key_release) last_ext = key_ext;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(4);
    ps2_clk = 1'b0;
    cyc(10);
    ps2_clk = 1'b1;
    cyc(6);
  endtask
  task automatic send_frame(input logic [7:0] c, input logic bad, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit(~^c ^ bad);
    send_bit(stp);
    ps2_data = 1'b1;
    cyc(10);
  endtask
  task automatic mark;
    bf = nflag;
    br = nrel;
    be = nerr;
  endtask
  function automatic vec_t mk(input logic [7:0] c, input logic bad, input logic stp,
                              input int ef, input int er, input int ee,
                              input logic [7:0] kp, input logic ext);
    vec_t r;
    r.code = c; r.bad_par = bad; r.stp = stp;
    r.ef = ef; r.er = er; r.ee = ee; r.kp = kp; r.ext = ext;
    return r;
  endfunction
  initial begin
    v[0]  = mk(8'h16, 0, 1, 1, 0, 0, 8'h16, 0);
    v[1]  = mk(8'hF0, 0, 1, 0, 0, 0, 8'h16, 0);
    v[2]  = mk(8'h16, 0, 1, 0, 1, 0, 8'h16, 0);
    v[3]  = mk(8'hE0, 0, 1, 0, 0, 0, 8'h16, 0);
    v[4]  = mk(8'h75, 0, 1, 1, 0, 0, 8'h75, 1);
    v[5]  = mk(8'h15, 0, 1, 1, 0, 0, 8'h15, 0);
    v[6]  = mk(8'hE0, 0, 1, 0, 0, 0, 8'h15, 0);
    v[7]  = mk(8'hF0, 0, 1, 0, 0, 0, 8'h15, 0);
    v[8]  = mk(8'h7C, 0, 1, 0, 1, 0, 8'h15, 1);
    v[9]  = mk(8'h1C, 0, 1, 1, 0, 0, 8'h1C, 0);
    v[10] = PAR ? mk(8'h15, 1, 1, 0, 0, 1, 8'h1C, 0) : mk(8'h15, 1, 1, 1, 0, 0, 8'h15, 0);
    v[11] = mk(8'hE0, 0, 1, 0, 0, 0, PAR ? 8'h1C : 8'h15, 0);
    v[12] = mk(8'h33, 0, 0, 0, 0, 1, PAR ? 8'h1C : 8'h15, 0);
    v[13] = mk(8'h22, 0, 1, 1, 0, 0, 8'h22, 0);
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("reset key_pressed", key_pressed, 8'h00);
    chk("reset pulses", {key_flag, key_ext, key_release, frame_err}, 0);
    for (int i = 0; i < 14; i++) begin
      mark();
      send_frame(v[i].code, v[i].bad_par, v[i].stp);
      chk($sformatf("vec%0d key_flag", i), nflag - bf, v[i].ef);
      chk($sformatf("vec%0d key_release", i), nrel - br, v[i].er);
      chk($sformatf("vec%0d frame_err", i), nerr - be, v[i].ee);
      chk($sformatf("vec%0d key_pressed", i), key_pressed, v[i].kp);
      if (v[i].ef + v[i].er > 0) chk($sformatf("vec%0d key_ext", i), last_ext, v[i].ext);
    end
    send_frame(8'hE0, 0, 1);
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(TO + 40);
    chk("timeout frame_err", nerr - be, 1);
    chk("timeout key_flag", nflag - bf, 0);
    mark();
    send_frame(8'h1C, 0, 1);
    chk("after timeout key_flag", nflag - bf, 1);
    chk("after timeout key_pressed", key_pressed, 8'h1C);
    chk("after timeout key_ext", last_ext, 0);
    chk("after timeout frame_err", nerr - be, 0);
    mark();
    ps2_data = 1'b0;
    cyc(4);
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
    cyc(20);
    send_frame(8'h29, 0, 1);
    chk("glitch key_flag", nflag - bf, 1);
    chk("glitch frame_err", nerr - be, 0);
    chk("glitch key_pressed", key_pressed, 8'h29);
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b1 : 1'b0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("midreset pulses", (nflag - bf) + (nrel - br) + (nerr - be), 0);
    chk("midreset key_pressed", key_pressed, 8'h00);
    mark();
    send_frame(8'h16, 0, 1);
    chk("post reset key_flag", nflag - bf, 1);
    chk("post reset key_pressed", key_pressed, 8'h16);
    chk("post reset frame_err", nerr - be, 0);
    chk("pulse exclusivity", nmulti, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
